// File: rtl/nn_feeder.sv
// Frame buffer that sits in front of a streaming classifier. It loads one frame
// of pixels, replays it as a gap-free burst on start, then captures the prediction.
module nn_feeder #(
    parameter int BITS     = 24,
    parameter int WIDTH    = 784,
    parameter int HEIGHT   = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    input  logic [BITS-1:0] s_data,
    output logic            s_ready,
    input  logic            start,
    output logic            nn_rst,
    output logic            nn_en,
    output logic [BITS-1:0] nn_pix,
    input  logic [BITS-1:0] nn_result,
    output logic [BITS-1:0] result,
    output logic            result_valid,
    output logic            result_err,
    output logic            busy,
    output logic [15:0]     frame_cnt
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [BITS-1:0] HEIGHT_W = BITS'(HEIGHT);

    typedef enum logic [2:0] {LOAD, FULL, CLEAR, STREAM, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] mem [WIDTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [DW-1:0]   drain_q, drain_d;
    logic            nn_en_q, nn_en_d;
    logic [BITS-1:0] nn_pix_q, nn_pix_d;
    logic [BITS-1:0] result_q, result_d;
    logic            err_q, err_d, rv_q, rv_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic            accept;

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign s_ready      = (state_q == LOAD) && !reset;
    assign accept       = s_valid && s_ready;
    assign rd_next      = rd_ptr_q + PW'(1);
    assign nn_rst       = (state_q == CLEAR);
    assign busy         = (state_q == CLEAR) || (state_q == STREAM) || (state_q == DRAIN);
    assign nn_en        = nn_en_q;
    assign nn_pix       = nn_pix_q;
    assign result       = result_q;
    assign result_err   = err_q;
    assign result_valid = rv_q;
    assign frame_cnt    = fcnt_q;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= s_data;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drain_d  = drain_q;
        nn_en_d  = 1'b0;
        nn_pix_d = '0;
        result_d = result_q;
        err_d    = err_q;
        rv_d     = 1'b0;
        fcnt_d   = fcnt_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wr_ptr_q == PW'(WIDTH - 1)) begin
                        wr_ptr_d = '0;
                        state_d  = FULL;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
            end
            FULL: if (start) state_d = CLEAR;
            CLEAR: begin
                rd_ptr_d = '0;
                nn_en_d  = 1'b1;
                nn_pix_d = mem[0];
                state_d  = STREAM;
            end
            STREAM: begin
                // rd_ptr_q is the beat currently on nn_pix; prefetch the next one.
                if (rd_ptr_q == PW'(WIDTH - 1)) begin
                    drain_d = '0;
                    state_d = DRAIN;
                end else begin
                    rd_ptr_d = rd_next;
                    nn_en_d  = 1'b1;
                    nn_pix_d = mem[rd_next];
                end
            end
            DRAIN: begin
                // Capture on the last drain edge so result/valid are visible during DONE.
                if (drain_q == DW'(PIPE_LAT - 1)) begin
                    result_d = nn_result;
                    err_d    = (nn_result >= HEIGHT_W);
                    rv_d     = 1'b1;
                    fcnt_d   = fcnt_q + 16'd1;
                    state_d  = DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drain_q  <= '0;
            nn_en_q  <= 1'b0;
            nn_pix_q <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            rv_q     <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drain_q  <= drain_d;
            nn_en_q  <= nn_en_d;
            nn_pix_q <= nn_pix_d;
            result_q <= result_d;
            err_q    <= err_d;
            rv_q     <= rv_d;
            fcnt_q   <= fcnt_d;
        end
    end
endmodule
